// File: rtl/regfile_wb.sv
// regfile_wb: write-back arbiter merging single-cycle ALU results and queued load results into one register-file write port
module regfile_wb #(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_valid,
    input  logic [4:0]             alu_rd,
    input  logic [31:0]            alu_data,
    output logic                   alu_hold,
    input  logic                   ld_valid,
    input  logic [4:0]             ld_rd,
    input  logic [31:0]            ld_data,
    output logic                   ld_ready,
    input  logic [4:0]             ra1,
    input  logic [4:0]             ra2,
    output logic                   pend1,
    output logic                   pend2,
    output logic                   en_write,
    output logic [4:0]             wa,
    output logic [31:0]            wdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] live;
    logic [4:0]       rd_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [AW-1:0]    rptr, wptr;
    logic             full, push, pop, alu_win, alu_kill, wr;

    assign full     = count == CW'(DEPTH);
    assign alu_hold = full;
    assign ld_ready = !full;
    assign push     = ld_valid && ld_ready && ld_rd != 5'd0;
    assign alu_win  = alu_valid && !full;
    assign alu_kill = alu_win && alu_rd != 5'd0;
    assign pop      = full || (!alu_valid && count != '0);
    assign wr       = pop ? live[rptr] : alu_kill;

    // The output register is excluded: the register file absorbs it before the read is used.
    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            pend1 = pend1 | (live[i] && rd_q[i] == ra1);
            pend2 = pend2 | (live[i] && rd_q[i] == ra2);
        end
        pend1 = pend1 && ra1 != 5'd0;
        pend2 = pend2 && ra2 != 5'd0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wptr]   <= ld_rd;
            data_q[wptr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live     <= '0;
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            en_write <= 1'b0;
            wa       <= 5'd0;
            wdata    <= 32'd0;
        end else begin
            // Queued loads are older than the ALU result, so a matching rd loses its write.
            for (int i = 0; i < DEPTH; i++)
                if (alu_kill && rd_q[i] == alu_rd) live[i] <= 1'b0;
            if (pop) begin
                live[rptr] <= 1'b0;
                rptr       <= rptr + AW'(1);
            end
            if (push) begin
                live[wptr] <= !(alu_kill && ld_rd == alu_rd);
                wptr       <= wptr + AW'(1);
            end
            count    <= count + CW'(push) - CW'(pop);
            en_write <= wr;
            if (wr) begin
                wa    <= pop ? rd_q[rptr] : alu_rd;
                wdata <= pop ? data_q[rptr] : alu_data;
            end
        end
    end
endmodule
